wg_reg_bank: RTL and testbench
==============================

Name: wg_reg_bank

Overview:
- Parametrised control/status register bank for the waveform generator.
- Generalises the fixed 8x8 control register file:
  - configurable register count and data width
  - per-register reset values and read-only masks
  - registered read-back port with valid handshake
  - per-register write strobes
  - sticky write-1-to-clear (W1C) error/status register fed by hardware event inputs
- Sits between the host-side byte interface and the MFSM/NCO/DAC/dump blocks, which decode fields from regs_o.

Parameters:
- DATA_W, 8: register width in bits.
- NUM_REGS, 8: number of registers, addresses 0..NUM_REGS-1; 2 <= NUM_REGS <= 2**ADDR_W.
- ADDR_W, 8: address bus width.
- RST_VAL, '0: flattened NUM_REGS*DATA_W reset values; register k uses slice [k*DATA_W +: DATA_W].
- RO_MASK, '0: flattened NUM_REGS*DATA_W; a 1 marks a bit host-read-only (write ignored).
- ERR_ADDR, NUM_REGS-1: address of the W1C error register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- addr_i  in  ADDR_W  host address, shared by read and write
- wr_data_i  in  DATA_W  host write data
- wr_en_i  in  1  write request, single-cycle qualifier
- rd_en_i  in  1  read request, single-cycle qualifier
- rd_data_o  out  DATA_W  read-back data
- rd_valid_o  out  1  rd_data_o valid, one-cycle pulse
- err_set_i  in  DATA_W  hardware event bits, OR-set into the error register
- regs_o  out  NUM_REGS*DATA_W  flattened current register contents
- wr_strobe_o  out  NUM_REGS  one-cycle pulse per register updated by a host write
- irq_o  out  1  high while any error register bit is set

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - register k <= RST_VAL slice k
  - error register <= 0
  - rd_data_o = 0, rd_valid_o = 0, wr_strobe_o = 0, irq_o = 0
  - reset has priority over every in-flight request; a read issued in the reset cycle never produces rd_valid_o.
- Write, wr_en_i=1 and addr_i < NUM_REGS and addr_i != ERR_ADDR:
  - next edge: reg[addr] <= (wr_data_i & ~RO) | (reg & RO)
  - wr_strobe_o[addr] pulses in the cycle after the edge, aligned with the new value on regs_o
  - the strobe fires even if the masked value is unchanged.
- Write to ERR_ADDR: W1C.
  - err <= (err & ~wr_data_i) | err_set_i | internal_err
  - a set in the same cycle beats a clear.
  - wr_strobe_o[ERR_ADDR] pulses.
- Hardware error input:
  - err <= err | err_set_i every cycle
  - bits are sticky until cleared by host.
- Internal error bits, reserved low bits of the error register, indices in the package:
  - ERR_WR_OOR (bit 0): write with addr_i >= NUM_REGS. Register contents unchanged, no strobe.
  - ERR_RD_OOR (bit 1): read with addr_i >= NUM_REGS. Read still completes, rd_data_o = 0.
  - ERR_WR_RO (bit 2): write sets a 1 on any RO_MASK bit of the target register. Writable bits are still updated.
  - These three bits are masked out of err_set_i, which drives bits DATA_W-1..3 only.
- Read:
  - rd_en_i sampled at edge N; rd_data_o = value of reg[addr_i] before edge N; rd_valid_o=1 for exactly the cycle after edge N.
  - Latency 1; back-to-back reads every cycle are supported.
  - Outside a valid cycle rd_data_o holds its last value.
- Simultaneous read and write to the same address: the read returns the old (pre-write) value.
- Reading ERR_ADDR returns the error value before that edge's set/clear.
- irq_o = |err, registered; follows the error register with zero extra delay.
- addr_i wider than needed: compare the full ADDR_W against NUM_REGS; no aliasing.

Decomposition:
- Package wg_reg_pkg:
  - ERR_WR_OOR=0, ERR_RD_OOR=1, ERR_WR_RO=2, ERR_HW_LSB=3
  - default register map address constants: MFSM_CTRL=0, NCO_CTRL0=1, NCO_CTRL1=2, DAC_CTRL=3, DUMP_CTRL=4, ERR=5
  - function to slice register k out of a flattened vector
- Sub-module wg_w1c_reg: one DATA_W sticky register with set vector, W1C clear vector, clear enable and the set-beats-clear rule. Instantiated once for ERR_ADDR.

Test Plan:
1. Reset with RST_VAL reg1=8'h5A, others 0 -> regs_o slice1=8'h5A, all others 0; rd_valid_o=0, irq_o=0, wr_strobe_o=0.
2. Write 8'hA5 to addr 3, then read addr 3 next cycle -> wr_strobe_o=8'b0000_1000 for one cycle; rd_valid_o one cycle later with rd_data_o=8'hA5.
3. Same cycle: write 8'h11 to addr 2 and read addr 2 (old value 8'h00) -> rd_data_o=8'h00; following read of addr 2 returns 8'h11.
4. RO_MASK reg4=8'hF0; write 8'hFF to addr 4 -> reg4=8'h0F, error bit 2 set, irq_o=1; W1C write 8'h04 to ERR_ADDR -> error=0, irq_o=0.
5. Write to addr 8'd20 with NUM_REGS=8; read addr 8'd20 -> all registers unchanged, error=8'h03, rd_data_o=0 with rd_valid_o=1.
6. err_set_i=8'h80 in the same cycle as W1C write 8'h80 -> bit 7 remains 1; W1C 8'h80 with err_set_i=0 -> bit 7 cleared. Asserting rst_n=0 mid-read -> no rd_valid_o pulse.

Source files
------------

// File: rtl/wg_reg_pkg.sv
// Shared constants for the waveform-generator register bank: error bit layout,
// default register map and a helper to pull one register out of a flattened vector.
package wg_reg_pkg;

    localparam int ERR_WR_OOR = 0;
    localparam int ERR_RD_OOR = 1;
    localparam int ERR_WR_RO  = 2;
    localparam int ERR_HW_LSB = 3;

    localparam int MFSM_CTRL = 0;
    localparam int NCO_CTRL0 = 1;
    localparam int NCO_CTRL1 = 2;
    localparam int DAC_CTRL  = 3;
    localparam int DUMP_CTRL = 4;
    localparam int ERR       = 5;

    localparam int SLICE_MAX_W = 4096;

    // Returns register k (width w, at most 64 bits) from a zero-extended flat vector.
    function automatic logic [63:0] reg_slice(input logic [SLICE_MAX_W-1:0] flat,
                                              input int k, input int w);
        logic [SLICE_MAX_W-1:0] sh;
        logic [63:0]            mask;
        sh   = flat >> (k * w);
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return sh[63:0] & mask;
    endfunction

endpackage

// File: rtl/wg_reg_bank_w1c.sv
// Sticky status register: set bits accumulate, host clears with write-1-to-clear.
// A set and a clear of the same bit in one cycle leaves the bit set.
module wg_w1c_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] set,
    input  logic [DATA_W-1:0] clr,
    input  logic              clr_en,
    output logic [DATA_W-1:0] q,
    output logic              any
);

    logic [DATA_W-1:0] nxt;

    always_comb begin
        nxt = q | set;
        if (clr_en) begin
            nxt = (q & ~clr) | set;
        end
    end

    // any is registered from the next value so it tracks q without extra delay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q   <= '0;
            any <= 1'b0;
        end else begin
            q   <= nxt;
            any <= |nxt;
        end
    end

endmodule

// File: rtl/wg_reg_bank.sv
// Parametrised control/status register bank with masked host writes, registered
// read-back (latency 1), per-register write strobes and a sticky W1C error register.
module wg_reg_bank
    import wg_reg_pkg::*;
#(
    parameter int                           DATA_W   = 8,
    parameter int                           NUM_REGS = 8,
    parameter int                           ADDR_W   = 8,
    parameter logic [NUM_REGS*DATA_W-1:0]   RST_VAL  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]   RO_MASK  = '0,
    parameter int                           ERR_ADDR = NUM_REGS - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         wr_en_i,
    input  logic                         rd_en_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic                         rd_valid_o,
    input  logic [DATA_W-1:0]            err_set_i,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_strobe_o,
    output logic                         irq_o
);

    localparam logic [DATA_W-1:0] HW_MASK = {{(DATA_W-ERR_HW_LSB){1'b1}}, {ERR_HW_LSB{1'b0}}};

    logic [NUM_REGS-1:0] wr_hit;
    logic                in_range;
    logic [DATA_W-1:0]   rd_next;
    logic [DATA_W-1:0]   ro_tgt;
    logic [DATA_W-1:0]   int_err;
    logic [DATA_W-1:0]   err_set;
    logic [DATA_W-1:0]   err_q;

    // Full-width compare (one extra bit) so high addresses never alias onto real registers.
    assign in_range = {1'b0, addr_i} < (ADDR_W+1)'(NUM_REGS);

    always_comb begin
        wr_hit  = '0;
        rd_next = '0;
        ro_tgt  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if ({1'b0, addr_i} == (ADDR_W+1)'(k)) begin
                wr_hit[k] = wr_en_i;
                rd_next   = regs_o[k*DATA_W +: DATA_W];
                ro_tgt    = RO_MASK[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        int_err             = '0;
        int_err[ERR_WR_OOR] = wr_en_i & ~in_range;
        int_err[ERR_RD_OOR] = rd_en_i & ~in_range;
        int_err[ERR_WR_RO]  = wr_en_i & in_range & (|(wr_data_i & ro_tgt));
    end

    assign err_set = (err_set_i & HW_MASK) | int_err;

    wg_w1c_reg #(.DATA_W(DATA_W)) u_err (
        .clk    (clk),
        .rst_n  (rst_n),
        .set    (err_set),
        .clr    (wr_data_i),
        .clr_en (wr_hit[ERR_ADDR]),
        .q      (err_q),
        .any    (irq_o)
    );

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (k == ERR_ADDR) begin : g_err
            assign regs_o[k*DATA_W +: DATA_W] = err_q;
        end else begin : g_rw
            localparam logic [DATA_W-1:0] RST_K = DATA_W'(reg_slice(SLICE_MAX_W'(RST_VAL), k, DATA_W));
            localparam logic [DATA_W-1:0] RO_K  = DATA_W'(reg_slice(SLICE_MAX_W'(RO_MASK), k, DATA_W));
            logic [DATA_W-1:0] q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q <= RST_K;
                end else if (wr_hit[k]) begin
                    q <= (wr_data_i & ~RO_K) | (q & RO_K);
                end
            end

            assign regs_o[k*DATA_W +: DATA_W] = q;
        end
    end

    // Read data captures pre-edge contents, so a same-cycle write or error update is not visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_o   <= '0;
            rd_valid_o  <= 1'b0;
            wr_strobe_o <= '0;
        end else begin
            rd_valid_o  <= rd_en_i;
            wr_strobe_o <= wr_hit;
            if (rd_en_i) begin
                rd_data_o <= in_range ? rd_next : '0;
            end
        end
    end

endmodule

// File: tb/tb_wg_reg_bank.sv
// Directed test of wg_reg_bank: read data checked through a scoreboard queue by an
// independent monitor; register, strobe and irq state checked inline after each step.
module tb_wg_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr_i;
    logic [7:0]  wr_data_i;
    logic        wr_en_i;
    logic        rd_en_i;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic [7:0]  err_set_i;
    logic [63:0] regs_o;
    logic [7:0]  wr_strobe_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    wg_reg_bank #(
        .DATA_W   (8),
        .NUM_REGS (8),
        .ADDR_W   (8),
        .RST_VAL  (64'h0000_0000_0000_5A00),
        .RO_MASK  (64'h0000_00F0_0000_0000),
        .ERR_ADDR (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_i      (addr_i),
        .wr_data_i   (wr_data_i),
        .wr_en_i     (wr_en_i),
        .rd_en_i     (rd_en_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .err_set_i   (err_set_i),
        .regs_o      (regs_o),
        .wr_strobe_o (wr_strobe_o),
        .irq_o       (irq_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs return to idle 1 time unit after the edge.
    task automatic cyc(input logic we, input logic re, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] es);
        wr_en_i   = we;
        rd_en_i   = re;
        addr_i    = a;
        wr_data_i = d;
        err_set_i = es;
        @(posedge clk);
        #1;
        wr_en_i   = 1'b0;
        rd_en_i   = 1'b0;
        err_set_i = 8'h00;
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid_o=1 data %h with no read pending", rd_data_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data_o !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h", rd_data_o, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; addr_i = '0; wr_data_i = '0; wr_en_i = 1'b0; rd_en_i = 1'b0; err_set_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_regs",   regs_o,      64'h0000_0000_0000_5A00);
        chk("rst_valid",  rd_valid_o,  0);
        chk("rst_irq",    irq_o,       0);
        chk("rst_strobe", wr_strobe_o, 0);

        // Write then read back addr 3
        cyc(1, 0, 8'd3, 8'hA5, 8'h00);
        chk("wr3_strobe", wr_strobe_o, 8'h08);
        chk("wr3_reg",    regs_o[31:24], 8'hA5);
        exp_q.push_back(8'hA5);
        cyc(0, 1, 8'd3, 8'h00, 8'h00);
        chk("wr3_strobe_end", wr_strobe_o, 8'h00);

        // Simultaneous read/write to addr 2 returns old value
        exp_q.push_back(8'h00);
        cyc(1, 1, 8'd2, 8'h11, 8'h00);
        chk("wr2_reg", regs_o[23:16], 8'h11);
        exp_q.push_back(8'h11);
        cyc(0, 1, 8'd2, 8'h00, 8'h00);

        // Read-only upper nibble of reg 4
        cyc(1, 0, 8'd4, 8'hFF, 8'h00);
        chk("ro_reg4",    regs_o[39:32], 8'h0F);
        chk("ro_err",     regs_o[63:56], 8'h04);
        chk("ro_irq",     irq_o,         1);
        chk("ro_strobe",  wr_strobe_o,   8'h10);
        cyc(1, 0, 8'd7, 8'h04, 8'h00);
        chk("w1c_err",    regs_o[63:56], 8'h00);
        chk("w1c_irq",    irq_o,         0);
        chk("w1c_strobe", wr_strobe_o,   8'h80);

        // Out-of-range write and read
        cyc(1, 0, 8'd20, 8'hFF, 8'h00);
        chk("oor_wr_regs",   regs_o[55:0], 56'h00_00_0F_A5_11_5A_00);
        chk("oor_wr_err",    regs_o[63:56], 8'h01);
        chk("oor_wr_strobe", wr_strobe_o,  8'h00);
        exp_q.push_back(8'h00);
        cyc(0, 1, 8'd20, 8'h00, 8'h00);
        chk("oor_rd_err", regs_o[63:56], 8'h03);
        chk("oor_rd_irq", irq_o,         1);
        cyc(1, 0, 8'd7, 8'h03, 8'h00);
        chk("oor_clr", regs_o[63:56], 8'h00);

        // Reading the error register sees the pre-edge value; low err_set bits are masked
        exp_q.push_back(8'h00);
        cyc(0, 1, 8'd7, 8'h00, 8'h0F);
        chk("hw_set", regs_o[63:56], 8'h08);
        exp_q.push_back(8'h08);
        cyc(1, 1, 8'd7, 8'h08, 8'h00);
        chk("hw_clr", regs_o[63:56], 8'h00);

        // Set beats clear
        cyc(1, 0, 8'd7, 8'h80, 8'h80);
        chk("set_beats_clr", regs_o[63:56], 8'h80);
        chk("set_irq",       irq_o,         1);
        cyc(1, 0, 8'd7, 8'h80, 8'h00);
        chk("clr_bit7",  regs_o[63:56], 8'h00);
        chk("clr_irq",   irq_o,         0);

        // Reset during a read: no valid pulse, registers back to reset values
        rst_n = 1'b0;
        cyc(1, 1, 8'd3, 8'hEE, 8'h00);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_regs",  regs_o,     64'h0000_0000_0000_5A00);
        chk("rst_rd_data",  rd_data_o,  8'h00);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rd_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
